// File: rtl/weighted_rr_burst_arbiter_if.sv
// Requester/resource-side bundle for the weighted round-robin burst arbiter.
// master drives requests, weights and beat strobes; slave (the arbiter) returns grants.
interface weighted_rr_burst_arbiter_if #(
    parameter int N  = 4,
    parameter int WW = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            beat;
    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_idx;
    logic            busy;

    modport master (
        output req,
        output weight,
        output beat,
        input  grant,
        input  grant_idx,
        input  busy
    );

    modport slave (
        input  req,
        input  weight,
        input  beat,
        output grant,
        output grant_idx,
        output busy
    );
endinterface

// File: rtl/weighted_rr_burst_arbiter.sv
// Weighted round-robin arbiter: a winner keeps the resource for up to weight[i]
// accepted beats (or until it drops req), then priority rotates past it.
module weighted_rr_burst_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    weighted_rr_burst_arbiter_if.slave    bus
);
    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] cnt_q, cnt_d;

    logic          tenure_end;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] arb_ptr;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [WW-1:0] win_weight;
    logic [WW-1:0] load_cnt;

    always_comb begin
        next_ptr = (grant_idx_q == IW'(N - 1)) ? '0 : grant_idx_q + IW'(1);
    end

    // A pending beat on the withdraw cycle folds into the same tenure end.
    always_comb begin
        tenure_end = (state_q == GRANT) &&
                     ((bus.beat && (cnt_q == WW'(1))) || !bus.req[grant_idx_q]);
        arb_ptr    = tenure_end ? next_ptr : ptr_q;
    end

    always_comb begin
        logic [IW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(arb_ptr) + k) % N);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_weight = bus.weight[int'(win_idx)*WW +: WW];
        load_cnt   = (win_weight == '0) ? WW'(1) : win_weight;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = GRANT;
                    grant_d     = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    grant_idx_d = win_idx;
                    cnt_d       = load_cnt;
                end
            end
            GRANT: begin
                if (tenure_end) begin
                    ptr_d = next_ptr;
                    if (win_found) begin
                        grant_d     = {{(N-1){1'b0}}, 1'b1} << win_idx;
                        grant_idx_d = win_idx;
                        cnt_d       = load_cnt;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end
                end else if (bus.beat) begin
                    cnt_d = cnt_q - WW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Gate by live req so a withdrawing owner loses grant in the same cycle.
    assign bus.grant     = grant_q & bus.req;
    assign bus.grant_idx = grant_idx_q;
    assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_weighted_rr_burst_arbiter.sv
// Directed-vector bench for weighted_rr_burst_arbiter: a per-cycle table plus
// hand-written sequences for withdrawal, zero weight and mid-tenure reset.
module tb_weighted_rr_burst_arbiter;
    logic clk;
    logic rst;

    weighted_rr_burst_arbiter_if #(.N(4), .WW(4)) bus ();

    weighted_rr_burst_arbiter #(.N(4), .WW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] weight;
        logic        beat;
        logic [3:0]  grant;
        logic [1:0]  idx;
        logic        busy;
    } vec_t;

    int n_vectors = 0;
    int n_miscompares = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [15:0] w,
                                input logic b, input logic [3:0] g, input logic [1:0] i,
                                input logic y);
        vec_t v;
        v.rst = r; v.req = q; v.weight = w; v.beat = b;
        v.grant = g; v.idx = i; v.busy = y;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst        = v.rst;
        bus.req    = v.req;
        bus.weight = v.weight;
        bus.beat   = v.beat;
    endtask

    // grant_idx is only meaningful while busy or held in reset.
    task automatic checkOutput(input vec_t v, input string tag);
        @(negedge clk);
        n_vectors++;
        if (bus.grant !== v.grant) begin
            n_miscompares++;
            $display("[TB] FAIL %s grant: got %b, expected %b", tag, bus.grant, v.grant);
        end
        if (bus.busy !== v.busy) begin
            n_miscompares++;
            $display("[TB] FAIL %s busy: got %b, expected %b", tag, bus.busy, v.busy);
        end
        if ((v.busy || v.rst) && (bus.grant_idx !== v.idx)) begin
            n_miscompares++;
            $display("[TB] FAIL %s grant_idx: got %0d, expected %0d", tag, bus.grant_idx, v.idx);
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        checkOutput(v, tag);
    endtask

    vec_t tbl[20];
    vec_t seq[$];

    initial begin
        rst        = 1'b1;
        bus.req    = '0;
        bus.weight = '0;
        bus.beat   = 1'b0;

        // Reset with all requesting, weights 2,1,1,1, continuous beats, then sole req[2] with weight 3.
        tbl[0]  = mk(1, 4'b1111, 16'h1112, 0, 4'b0000, 2'd0, 0);
        tbl[1]  = mk(0, 4'b1111, 16'h1112, 0, 4'b0000, 2'd0, 0);
        tbl[2]  = mk(0, 4'b1111, 16'h1112, 1, 4'b0001, 2'd0, 1);
        tbl[3]  = mk(0, 4'b1111, 16'h1112, 1, 4'b0001, 2'd0, 1);
        tbl[4]  = mk(0, 4'b1111, 16'h1112, 1, 4'b0010, 2'd1, 1);
        tbl[5]  = mk(0, 4'b1111, 16'h1112, 1, 4'b0100, 2'd2, 1);
        tbl[6]  = mk(0, 4'b1111, 16'h1112, 1, 4'b1000, 2'd3, 1);
        tbl[7]  = mk(0, 4'b1111, 16'h1112, 1, 4'b0001, 2'd0, 1);
        tbl[8]  = mk(0, 4'b1111, 16'h1112, 1, 4'b0001, 2'd0, 1);
        tbl[9]  = mk(0, 4'b0100, 16'h0300, 1, 4'b0000, 2'd1, 1);
        tbl[10] = mk(0, 4'b0100, 16'h0300, 1, 4'b0100, 2'd2, 1);
        tbl[11] = mk(0, 4'b0100, 16'h0300, 1, 4'b0100, 2'd2, 1);
        tbl[12] = mk(0, 4'b0100, 16'h0300, 1, 4'b0100, 2'd2, 1);
        tbl[13] = mk(0, 4'b0100, 16'h0300, 1, 4'b0100, 2'd2, 1);
        tbl[14] = mk(0, 4'b0100, 16'h0300, 1, 4'b0100, 2'd2, 1);
        tbl[15] = mk(0, 4'b0101, 16'h0300, 1, 4'b0100, 2'd2, 1);
        tbl[16] = mk(0, 4'b0101, 16'h0300, 0, 4'b0001, 2'd0, 1);
        tbl[17] = mk(0, 4'b0101, 16'h0300, 1, 4'b0001, 2'd0, 1);
        tbl[18] = mk(0, 4'b0000, 16'h0300, 0, 4'b0100, 2'd2, 1);
        tbl[19] = mk(0, 4'b0000, 16'h0300, 0, 4'b0000, 2'd0, 0);
        tbl[18].grant = 4'b0000;

        for (int i = 0; i < 20; i++) begin
            runVector(tbl[i], $sformatf("tbl%0d", i));
        end

        // Owner 1 (weight 4) withdraws after one beat while req[3] waits; then ptr wrap 3->0.
        runVector(mk(1, 4'b0000, 16'h0040, 0, 4'b0000, 2'd0, 0), "wd_reset");
        runVector(mk(0, 4'b1010, 16'h0040, 0, 4'b0000, 2'd0, 0), "wd_idle");
        runVector(mk(0, 4'b1010, 16'h0040, 1, 4'b0010, 2'd1, 1), "wd_owner1");
        runVector(mk(0, 4'b1000, 16'h0040, 0, 4'b0000, 2'd1, 1), "wd_drop");
        runVector(mk(0, 4'b1000, 16'h0040, 0, 4'b1000, 2'd3, 1), "wd_next3");
        runVector(mk(0, 4'b0000, 16'h0040, 0, 4'b0000, 2'd3, 1), "wd_drop3");
        runVector(mk(0, 4'b1111, 16'h0040, 0, 4'b0000, 2'd0, 0), "wd_idle2");
        runVector(mk(0, 4'b1111, 16'h0040, 0, 4'b0001, 2'd0, 1), "wd_wrap");

        // Zero weights behave as one beat; beats in IDLE leave ptr alone.
        runVector(mk(1, 4'b0000, 16'h0000, 1, 4'b0000, 2'd0, 0), "zw_reset");
        for (int i = 0; i < 3; i++) begin
            runVector(mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 2'd0, 0), $sformatf("zw_idlebeat%0d", i));
        end
        runVector(mk(0, 4'b0011, 16'h0000, 0, 4'b0000, 2'd0, 0), "zw_req");
        runVector(mk(0, 4'b0011, 16'h0000, 1, 4'b0001, 2'd0, 1), "zw_own0");
        runVector(mk(0, 4'b0001, 16'h0000, 0, 4'b0000, 2'd1, 1), "zw_own1");
        runVector(mk(0, 4'b0001, 16'h0000, 1, 4'b0001, 2'd0, 1), "zw_sole0");
        runVector(mk(0, 4'b0001, 16'h0000, 0, 4'b0001, 2'd0, 1), "zw_regrant");

        // Reset mid-tenure (owner 2, cnt 2), then a fresh tenure must reload cnt=3.
        seq.push_back(mk(1, 4'b0000, 16'h0300, 0, 4'b0000, 2'd0, 0));
        seq.push_back(mk(0, 4'b0100, 16'h0300, 0, 4'b0000, 2'd0, 0));
        seq.push_back(mk(0, 4'b0100, 16'h0300, 1, 4'b0100, 2'd2, 1));
        seq.push_back(mk(1, 4'b0100, 16'h0300, 0, 4'b0000, 2'd0, 0));
        seq.push_back(mk(0, 4'b0100, 16'h0300, 0, 4'b0000, 2'd0, 0));
        seq.push_back(mk(0, 4'b0100, 16'h0300, 1, 4'b0100, 2'd2, 1));
        seq.push_back(mk(0, 4'b0110, 16'h0300, 1, 4'b0100, 2'd2, 1));
        seq.push_back(mk(0, 4'b0110, 16'h0300, 1, 4'b0100, 2'd2, 1));
        seq.push_back(mk(0, 4'b0110, 16'h0300, 0, 4'b0010, 2'd1, 1));
        foreach (seq[i]) begin
            runVector(seq[i], $sformatf("mr%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
